// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared ISA constants for the fetch stage and its decoder.
//   - opcode / funct encodings recognised by the control FSM
//   - instruction-register field bit positions
//   - fetch FSM state encoding
package mips_isa_pkg;

  // Opcodes (ir[31:26])
  localparam logic [5:0] OP_R        = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLE      = 6'h06;
  localparam logic [5:0] OP_BGT      = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_RESET_OP = 6'h3F;

  // R-type funct codes (ir[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_JR  = 6'h08;

  // IR field bit positions (msb/lsb)
  localparam int OPCODE_MSB = 31, OPCODE_LSB = 26;
  localparam int RS_MSB     = 25, RS_LSB     = 21;
  localparam int RT_MSB     = 20, RT_LSB     = 16;
  localparam int RD_MSB     = 15, RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10, SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5,  FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15, IMM_LSB    = 0;
  localparam int JT_MSB     = 25, JT_LSB     = 0;

  // Fetch FSM states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_field_decoder.sv
// instr_field_decoder: purely combinational slicing of the instruction
// register into MIPS fields, sign extension of the immediate, and the
// reset-opcode / illegal-opcode flags.
// Optional feature macro: ILLEGAL_OP_DETECT_EN (when undefined illegal_op
// is tied low and no opcode/funct decode is built).
// Ports: ir, instr_valid in; opcode, rs, rt, rd, shamt, funct, imm_sext,
//        jtarget, is_reset_op, illegal_op out.
module instr_field_decoder
  import mips_isa_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [25:0] jtarget,
  output logic        is_reset_op,
  output logic        illegal_op
);

  assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
  assign rs       = ir[RS_MSB:RS_LSB];
  assign rt       = ir[RT_MSB:RT_LSB];
  assign rd       = ir[RD_MSB:RD_LSB];
  assign shamt    = ir[SHAMT_MSB:SHAMT_LSB];
  assign funct    = ir[FUNCT_MSB:FUNCT_LSB];
  assign imm_sext = {{16{ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
  assign jtarget  = ir[JT_MSB:JT_LSB];

  assign is_reset_op = instr_valid && (opcode == OP_RESET_OP);

`ifdef ILLEGAL_OP_DETECT_EN
  logic op_known, fn_known;

  always_comb begin
    op_known = 1'b0;
    case (opcode)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLE, OP_BGT, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW,
      OP_RESET_OP: op_known = 1'b1;
      default:     op_known = 1'b0;
    endcase
  end

  always_comb begin
    fn_known = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_JR: fn_known = 1'b1;
      default:                       fn_known = 1'b0;
    endcase
  end

  // Only R-type words have their funct field checked.
  assign illegal_op = instr_valid &&
                      (!op_known || ((opcode == OP_R) && !fn_known));
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle fetch stage. On an aligned fetch_req in
// IDLE it holds mem_rd for MEM_LATENCY cycles at the latched address,
// captures mem_rdata into IR on the last cycle and raises instr_valid.
// Misaligned requests pulse addr_err for one cycle; flush aborts WAIT.
// Optional feature macro: ILLEGAL_OP_DETECT_EN (see instr_field_decoder).
// Ports: clk, reset (async active-low), fetch_req, flush, pc, mem_rdata in;
//        mem_addr, mem_rd, busy, instr_valid, addr_err, ir and decoded
//        fields (opcode..jtarget, is_reset_op, illegal_op) out.
module instr_fetch_unit
  import mips_isa_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,          // 1..15
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        instr_valid,
  output logic        addr_err,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [25:0] jtarget,
  output logic        is_reset_op,
  output logic        illegal_op
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

  fetch_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  ir_q, ir_d;
  logic         valid_q, valid_d;
  logic         addr_err_q, addr_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ir_q       <= RESET_INSTR;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    valid_d    = valid_q;
    addr_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // flush is deliberately ignored here: it only aborts WAIT.
        if (fetch_req) begin
          if (pc[1:0] == 2'b00) begin
            addr_d  = pc;
            cnt_d   = LAT_INIT;
            valid_d = 1'b0;
            state_d = WAIT;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        // flush wins over a capture on the same edge; valid already 0.
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          ir_d    = mem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd      = (state_q == WAIT);
  assign busy        = (state_q == WAIT);
  assign mem_addr    = addr_q;
  assign instr_valid = valid_q;
  assign addr_err    = addr_err_q;
  assign ir          = ir_q;

  instr_field_decoder u_dec (
    .ir          (ir_q),
    .instr_valid (valid_q),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm_sext    (imm_sext),
    .jtarget     (jtarget),
    .is_reset_op (is_reset_op),
    .illegal_op  (illegal_op)
  );

endmodule
